// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and winner-select helper for the
// interrupt pending controller.
package irq_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [0:0] {
    IRQ_IDLE    = 1'b0,
    IRQ_PRESENT = 1'b1
  } irq_state_t;

  // Highest set bit wins; later iterations overwrite earlier ones.
  function automatic logic [IDX_W-1:0] highest_set_idx(input logic [N_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit multi-flop synchroniser followed by a rising-edge detector.
// rise_o is high for one cycle when a synchronised line goes 0 -> 1.
module irq_sync_edge #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] rise_o
);

  // Fewer than two stages is not a synchroniser; clamp rather than misbehave.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int s = 1; s < STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky pending capture, masked encoder feed and valid/ready index presentation.
// Define IRQ_OVERFLOW_EN to add the ovf/ovf_clr repeat-edge overflow flags.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  input  logic             enable,
  output logic [N_REQ-1:0] pend_out,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  input  logic             irq_ready
`ifdef IRQ_OVERFLOW_EN
  ,
  output logic [N_REQ-1:0] ovf,
  input  logic [N_REQ-1:0] ovf_clr
`endif
);

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] pending_d;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] clr_vec;
  logic             accept;
  irq_state_t       state_q;

  irq_sync_edge #(
    .WIDTH       (N_REQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (req_in),
    .rise_o  (rise)
  );

  assign eligible = pending_q & mask;
  assign accept   = (state_q == IRQ_PRESENT) && irq_valid && irq_ready;

  // A fresh rise on the bit being retired survives, so the request is not lost.
  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[irq_idx] = 1'b1;
    pending_d = (pending_q & ~clr_vec) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      pend_out  <= '0;
    end else begin
      pending_q <= pending_d;
      pend_out  <= pending_q & mask;
    end
  end

  // irq_idx is frozen for the whole PRESENT state regardless of mask/enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IRQ_IDLE;
      irq_valid <= 1'b0;
      irq_idx   <= '0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (enable && (|eligible)) begin
            irq_idx   <= highest_set_idx(eligible);
            irq_valid <= 1'b1;
            state_q   <= IRQ_PRESENT;
          end
        end
        IRQ_PRESENT: begin
          if (irq_ready) begin
            irq_valid <= 1'b0;
            state_q   <= IRQ_IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state_q   <= IRQ_IDLE;
        end
      endcase
    end
  end

`ifdef IRQ_OVERFLOW_EN
  logic [N_REQ-1:0] ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr) | (rise & pending_q);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed self-checking bench for irq_pending_ctrl; overflow checks run
// only when IRQ_OVERFLOW_EN is defined.
module tb_irq_pending_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] req_in;
  logic [15:0] mask;
  logic        enable;
  logic [15:0] pend_out;
  logic        irq_valid;
  logic [3:0]  irq_idx;
  logic        irq_ready;
`ifdef IRQ_OVERFLOW_EN
  logic [15:0] ovf;
  logic [15:0] ovf_clr;
`endif

  int total = 0;
  int bad   = 0;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .enable    (enable),
    .pend_out  (pend_out),
    .irq_valid (irq_valid),
    .irq_idx   (irq_idx),
    .irq_ready (irq_ready)
`ifdef IRQ_OVERFLOW_EN
    ,
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("check %s ok (%0h)", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle pulse: req lines are captured by the first synchroniser flop.
  task automatic pulse(input logic [15:0] v);
    req_in = req_in | v;
    tick();
    req_in = req_in & ~v;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !irq_valid; i++) tick();
    check_eq(tag, 32'(irq_valid), 32'd1);
  endtask

  task automatic accept_one();
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_in    = 16'hFFFF;
    mask      = 16'hFFFF;
    enable    = 1'b1;
    irq_ready = 1'b0;
`ifdef IRQ_OVERFLOW_EN
    ovf_clr   = 16'h0000;
`endif

    // Reset held with all requests high
    ticks(3);
    check_eq("rst_pend", 32'(pend_out), 32'h0);
    check_eq("rst_valid", 32'(irq_valid), 32'h0);
    check_eq("rst_idx", 32'(irq_idx), 32'h0);
    rst_n  = 1'b1;
    req_in = 16'h0000;
    tick();
    check_eq("rel_pend", 32'(pend_out), 32'h0);
    check_eq("rel_valid", 32'(irq_valid), 32'h0);
    check_eq("rel_idx", 32'(irq_idx), 32'h0);
    ticks(3);
    check_eq("idle_valid", 32'(irq_valid), 32'h0);

    // Single request latency: captured at edge K, pending K+2, valid K+3
    pulse(16'h0020);
    tick();
    tick();
    check_eq("lat_k2_valid", 32'(irq_valid), 32'h0);
    check_eq("lat_k2_pend", 32'(pend_out), 32'h0);
    tick();
    check_eq("lat_k3_valid", 32'(irq_valid), 32'h1);
    check_eq("lat_k3_idx", 32'(irq_idx), 32'h5);
    check_eq("lat_k3_pend", 32'(pend_out), 32'h0020);
    accept_one();
    check_eq("lat_acc_valid", 32'(irq_valid), 32'h0);
    check_eq("lat_acc_pend", 32'(pend_out), 32'h0020);
    tick();
    check_eq("lat_clr_pend", 32'(pend_out), 32'h0);

    // Priority and stability
    pulse(16'h0208);
    wait_valid("pri_wait");
    check_eq("pri_idx9", 32'(irq_idx), 32'h9);
    pulse(16'h8000);
    ticks(3);
    check_eq("stab_valid", 32'(irq_valid), 32'h1);
    check_eq("stab_idx9", 32'(irq_idx), 32'h9);
    check_eq("stab_pend", 32'(pend_out), 32'h8208);
    irq_ready = 1'b1;
    tick();
    check_eq("b2b_bub1", 32'(irq_valid), 32'h0);
    tick();
    check_eq("b2b_v15", 32'(irq_valid), 32'h1);
    check_eq("b2b_idx15", 32'(irq_idx), 32'hF);
    tick();
    check_eq("b2b_bub2", 32'(irq_valid), 32'h0);
    tick();
    check_eq("b2b_v3", 32'(irq_valid), 32'h1);
    check_eq("b2b_idx3", 32'(irq_idx), 32'h3);
    tick();
    check_eq("b2b_bub3", 32'(irq_valid), 32'h0);
    irq_ready = 1'b0;
    tick();
    check_eq("b2b_pend", 32'(pend_out), 32'h0);

    // Masked request stays pending but invisible
    mask = 16'h00FF;
    pulse(16'h1000);
    ticks(4);
    check_eq("mask_valid", 32'(irq_valid), 32'h0);
    check_eq("mask_pend", 32'(pend_out), 32'h0);
    mask = 16'hFFFF;
    tick();
    check_eq("unmask_valid", 32'(irq_valid), 32'h1);
    check_eq("unmask_idx", 32'(irq_idx), 32'hC);
    check_eq("unmask_pend", 32'(pend_out), 32'h1000);
    accept_one();
    check_eq("unmask_acc", 32'(irq_valid), 32'h0);
    tick();

    // Enable gates selection in IDLE only
    enable = 1'b0;
    pulse(16'h0012);
    ticks(4);
    check_eq("en0_valid", 32'(irq_valid), 32'h0);
    check_eq("en0_pend", 32'(pend_out), 32'h0012);
    enable = 1'b1;
    tick();
    check_eq("en1_valid", 32'(irq_valid), 32'h1);
    check_eq("en1_idx", 32'(irq_idx), 32'h4);
    enable = 1'b0;
    tick();
    check_eq("en_hold_valid", 32'(irq_valid), 32'h1);
    check_eq("en_hold_idx", 32'(irq_idx), 32'h4);
    enable = 1'b1;
    irq_ready = 1'b1;
    tick();
    check_eq("en_acc4", 32'(irq_valid), 32'h0);
    tick();
    check_eq("en_v1", 32'(irq_valid), 32'h1);
    check_eq("en_idx1", 32'(irq_idx), 32'h1);
    tick();
    check_eq("en_acc1", 32'(irq_valid), 32'h0);
    irq_ready = 1'b0;
    tick();

    // New rise on bit 7 lands on the same edge as acceptance of index 7
    pulse(16'h0080);
    wait_valid("sc_wait");
    check_eq("sc_idx7", 32'(irq_idx), 32'h7);
    ticks(2);
    pulse(16'h0080);
    tick();
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    check_eq("sc_acc", 32'(irq_valid), 32'h0);
    tick();
    check_eq("sc_again_v", 32'(irq_valid), 32'h1);
    check_eq("sc_again_idx", 32'(irq_idx), 32'h7);
    check_eq("sc_again_pend", 32'(pend_out), 32'h0080);
    accept_one();
    ticks(2);
    check_eq("sc_clr_pend", 32'(pend_out), 32'h0);

`ifdef IRQ_OVERFLOW_EN
    // Repeat edge on an already-pending bit raises ovf
    check_eq("ovf_init", 32'(ovf), 32'h0);
    pulse(16'h0004);
    wait_valid("ovf_wait");
    check_eq("ovf_idx2", 32'(irq_idx), 32'h2);
    ticks(2);
    pulse(16'h0004);
    ticks(2);
    check_eq("ovf_set", 32'(ovf), 32'h0004);
    ovf_clr = 16'h0004;
    tick();
    ovf_clr = 16'h0000;
    check_eq("ovf_clr", 32'(ovf), 32'h0);
    check_eq("ovf_pend", 32'(pend_out), 32'h0004);
    accept_one();
    ticks(2);
`endif

    // Reset in the middle of a presentation
    pulse(16'h0440);
    wait_valid("mid_wait");
    check_eq("mid_idx10", 32'(irq_idx), 32'hA);
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_valid", 32'(irq_valid), 32'h0);
    check_eq("mid_async_idx", 32'(irq_idx), 32'h0);
    check_eq("mid_async_pend", 32'(pend_out), 32'h0);
    tick();
    rst_n = 1'b1;
    ticks(4);
    check_eq("mid_post_valid", 32'(irq_valid), 32'h0);
    check_eq("mid_post_pend", 32'(pend_out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
